fc_sequencer: RTL and testbench
===============================

# fc_sequencer

Layer sequencer directly upstream of the fully-connected MAC core. On a start pulse it walks NUM_OUT output neurons. For each neuron it:
- clears the core;
- streams NUM_IN node/weight pairs from external synchronous memories into the core, with the bias presented on the first pair only;
- captures the 32-bit accumulated result and hands it to the downstream consumer over a valid/ready interface.

It owns all addressing and timing, so the core stays a pure accumulate unit.

## Interface
- IN_DATA_WITDH, 8, width of node, weight and bias words
- NUM_IN, 16, inputs per neuron (≥2)
- NUM_OUT, 8, neurons per layer (≥2)
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_start  in  1  start-layer pulse; honoured only in IDLE
- o_busy  out  1  high from the cycle after accepted start until o_done
- o_done  out  1  one-cycle pulse after the last result handshake
- o_mem_en  out  1  read enable shared by all three memories
- o_node_addr  out  clog2(NUM_IN)  node memory address
- o_wegt_addr  out  clog2(NUM_IN*NUM_OUT)  weight address = neuron*NUM_IN + k
- o_bias_addr  out  clog2(NUM_OUT)  bias address = neuron
- i_node_data, i_wegt_data, i_bias_data  in  IN_DATA_WITDH  signed read data, valid one cycle after o_mem_en
- o_core_run  out  1  core clear
- o_core_valid  out  1  core accumulate enable
- o_core_node, o_core_wegt, o_core_bias  out  IN_DATA_WITDH  registered core operands
- i_core_result  in  4*IN_DATA_WITDH  core accumulator
- o_res_valid  out  1  result valid
- i_res_ready  in  1  consumer ready
- o_res_data  out  4*IN_DATA_WITDH  signed result
- o_res_idx  out  clog2(NUM_OUT)  neuron index of o_res_data

## Operation
- States:
  - IDLE → CLEAR on i_start.
  - CLEAR (1 cycle, o_core_run=1) → FEED.
  - FEED (NUM_IN cycles, o_mem_en=1, k=0..NUM_IN-1) → DRAIN.
  - DRAIN (3 cycles) → OUT.
  - OUT → CLEAR (next neuron) or DONE on handshake.
  - DONE (1 cycle, o_done=1) → IDLE.
- Operand pipeline:
  - Read data is registered into o_core_* one cycle after arrival.
  - o_core_valid is the twice-delayed o_mem_en.
- Bias gating: o_core_bias takes i_bias_data only for k=0 and zero otherwise. The core adds bias on every valid, so the net result is Σ node·wegt + bias.
- Result capture: o_res_data is loaded from i_core_result on the last DRAIN cycle. It is held stable while o_res_valid=1 and i_res_ready=0.
- Handshake: a transfer occurs when o_res_valid & i_res_ready. o_res_valid drops the following cycle unless a new result is ready; it never drops before the transfer.
- i_start is ignored outside IDLE, including during DONE.
- Reset (any time, including mid-FEED): every output goes to 0 asynchronously and the FSM returns to IDLE. No partial result is emitted afterwards.
- Arithmetic: no width change inside this block. The result is passed through at 4*IN_DATA_WITDH bits, signed.

## Timing
- Per neuron: 1 CLEAR + NUM_IN FEED + 3 DRAIN + ≥1 OUT = NUM_IN+5 cycles with i_res_ready tied high.
- Address issued in cycle t → core valid in t+2 → core accumulator updated at the end of t+2 → capture in t+3 (the last DRAIN cycle for the final k).
- o_busy rises the cycle after i_start. It falls in the same cycle o_done pulses.
- First o_res_valid appears NUM_IN+5 cycles after i_start.
- Total layer with no backpressure: NUM_OUT*(NUM_IN+5)+2 cycles from i_start to o_done.

## Configuration
- FC_SEQ_RELU_EN defined: captured results are clamped (negative → 0) before loading into o_res_data.
- FC_SEQ_RELU_EN undefined: the raw signed accumulator is forwarded.
- Timing is identical in both builds.

## Structure
- Shared package fc_pkg holds:
  - the FSM state encoding (IDLE, CLEAR, FEED, DRAIN, OUT, DONE);
  - the DRAIN_CYCLES=3 constant;
  - the address-width localparam helpers.
- No sub-module. The counters (k, neuron) and the operand pipeline stay inline.
- The core is instantiated beside this block by the parent.

## Test plan
- NUM_IN=4, NUM_OUT=2, nodes {1,2,3,4}, weights row0 {1,1,1,1}, row1 {-1,2,-3,4}, bias {10,-5}, paired with the real core → results 20 (idx 0) then 5 (idx 1), o_done once.
- Same stimulus with i_res_ready low for 5 cycles in OUT → o_res_data stays 20, o_res_valid held high, no neuron-1 reads until the handshake.
- Row0 weights {-10,-10,-10,-10}, bias 0 → -100 without FC_SEQ_RELU_EN; 0 with it.
- i_start pulsed again mid-FEED → ignored: exactly 2 results and 1 o_done.
- reset_n low during FEED of neuron 1 → all outputs 0 immediately; after release and a new i_start, both results are correct.
- Cycle check: i_start → first o_res_valid in exactly 9 cycles; o_done at cycle 20 with ready tied high.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared types and constants for the fully-connected layer sequencer.
package fc_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        OUT   = 3'd4,
        DONE  = 3'd5
    } state_e;

    // Cycles between the last address issue and a settled core accumulator.
    localparam int DRAIN_CYCLES = 3;

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fc_sequencer.sv
// Layer sequencer feeding the FC MAC core: addressing, operand pipeline, result handoff.
// Build option FC_SEQ_RELU_EN clamps negative results to zero at capture.
module fc_sequencer
    import fc_pkg::*;
#(
    parameter  int IN_DATA_WITDH = 8,
    parameter  int NUM_IN        = 16,
    parameter  int NUM_OUT       = 8,
    localparam int NODE_AW       = addr_w(NUM_IN),
    localparam int WEGT_AW       = addr_w(NUM_IN * NUM_OUT),
    localparam int BIAS_AW       = addr_w(NUM_OUT),
    localparam int RES_W         = 4 * IN_DATA_WITDH
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_start,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_mem_en,
    output logic [NODE_AW-1:0]       o_node_addr,
    output logic [WEGT_AW-1:0]       o_wegt_addr,
    output logic [BIAS_AW-1:0]       o_bias_addr,
    input  logic [IN_DATA_WITDH-1:0] i_node_data,
    input  logic [IN_DATA_WITDH-1:0] i_wegt_data,
    input  logic [IN_DATA_WITDH-1:0] i_bias_data,
    output logic                     o_core_run,
    output logic                     o_core_valid,
    output logic [IN_DATA_WITDH-1:0] o_core_node,
    output logic [IN_DATA_WITDH-1:0] o_core_wegt,
    output logic [IN_DATA_WITDH-1:0] o_core_bias,
    input  logic [RES_W-1:0]         i_core_result,
    output logic                     o_res_valid,
    input  logic                     i_res_ready,
    output logic [RES_W-1:0]         o_res_data,
    output logic [BIAS_AW-1:0]       o_res_idx,
    output state_e                   o_state
);

    localparam logic [NODE_AW-1:0] K_LAST     = NODE_AW'(NUM_IN - 1);
    localparam logic [BIAS_AW-1:0] N_LAST     = BIAS_AW'(NUM_OUT - 1);
    localparam logic [1:0]         DRAIN_LAST = 2'(DRAIN_CYCLES - 1);
    localparam logic [WEGT_AW-1:0] ROW_STRIDE = WEGT_AW'(NUM_IN);

    state_e               state_q, state_d;
    logic [NODE_AW-1:0]   k_q, k_d;
    logic [BIAS_AW-1:0]   neuron_q, neuron_d;
    logic [1:0]           drain_q, drain_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 res_valid_q, res_valid_d;
    logic [RES_W-1:0]     res_data_q, res_data_d;
    logic [BIAS_AW-1:0]   res_idx_q, res_idx_d;
    logic [RES_W-1:0]     capture;

    logic                     feed_d1_q, first_d1_q, core_valid_q;
    logic [IN_DATA_WITDH-1:0] core_node_q, core_wegt_q, core_bias_q;

`ifdef FC_SEQ_RELU_EN
    assign capture = i_core_result[RES_W-1] ? '0 : i_core_result;
`else
    assign capture = i_core_result;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            neuron_q    <= '0;
            drain_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            neuron_q    <= neuron_d;
            drain_q     <= drain_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_idx_q   <= res_idx_d;
        end
    end

    // Handshake: a result transfers on any cycle with o_res_valid & i_res_ready;
    // o_res_valid/o_res_data/o_res_idx hold steady until that transfer.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        neuron_d    = neuron_q;
        drain_d     = drain_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_idx_d   = res_idx_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d  = CLEAR;
                    busy_d   = 1'b1;
                    neuron_d = '0;
                end
            end
            CLEAR: begin
                k_d     = '0;
                drain_d = '0;
                state_d = FEED;
            end
            FEED: begin
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = DRAIN;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d     = OUT;
                    res_valid_d = 1'b1;
                    res_data_d  = capture;
                    res_idx_d   = neuron_q;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            OUT: begin
                if (i_res_ready) begin
                    res_valid_d = 1'b0;
                    if (neuron_q == N_LAST) begin
                        state_d = DONE;
                    end else begin
                        neuron_d = neuron_q + 1'b1;
                        state_d  = CLEAR;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Read data lands one cycle after the address; bias only rides on k=0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            feed_d1_q    <= 1'b0;
            first_d1_q   <= 1'b0;
            core_valid_q <= 1'b0;
            core_node_q  <= '0;
            core_wegt_q  <= '0;
            core_bias_q  <= '0;
        end else begin
            feed_d1_q    <= o_mem_en;
            first_d1_q   <= o_mem_en && (k_q == '0);
            core_valid_q <= feed_d1_q;
            if (feed_d1_q) begin
                core_node_q <= i_node_data;
                core_wegt_q <= i_wegt_data;
                core_bias_q <= first_d1_q ? i_bias_data : '0;
            end else begin
                core_node_q <= '0;
                core_wegt_q <= '0;
                core_bias_q <= '0;
            end
        end
    end

    assign o_mem_en     = (state_q == FEED);
    assign o_node_addr  = k_q;
    assign o_bias_addr  = neuron_q;
    assign o_wegt_addr  = WEGT_AW'(neuron_q) * ROW_STRIDE + WEGT_AW'(k_q);
    assign o_core_run   = (state_q == CLEAR);
    assign o_core_valid = core_valid_q;
    assign o_core_node  = core_node_q;
    assign o_core_wegt  = core_wegt_q;
    assign o_core_bias  = core_bias_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_res_valid  = res_valid_q;
    assign o_res_data   = res_data_q;
    assign o_res_idx    = res_idx_q;
    assign o_state      = state_q;

endmodule

// File: tb/tb_fc_sequencer.sv
// Directed bench for fc_sequencer with behavioural memories, a behavioural MAC core and a result scoreboard.
module tb_fc_sequencer;

    localparam int W   = 8;
    localparam int NI  = 4;
    localparam int NO  = 2;
    localparam int RW  = 4 * W;
    localparam int NAW = 2;
    localparam int WAW = 3;
    localparam int BAW = 1;
    localparam int SBW = RW + BAW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic                 i_start, i_res_ready;
    logic                 o_busy, o_done, o_mem_en, o_core_run, o_core_valid, o_res_valid;
    logic [NAW-1:0]       o_node_addr;
    logic [WAW-1:0]       o_wegt_addr;
    logic [BAW-1:0]       o_bias_addr, o_res_idx;
    logic [W-1:0]         node_rd, wegt_rd, bias_rd;
    logic [W-1:0]         o_core_node, o_core_wegt, o_core_bias;
    logic signed [RW-1:0] acc;
    logic [RW-1:0]        o_res_data;
    fc_pkg::state_e       dbg_state;

    fc_sequencer #(.IN_DATA_WITDH(W), .NUM_IN(NI), .NUM_OUT(NO)) dut (
        .clk(clk), .reset_n(reset_n), .i_start(i_start),
        .o_busy(o_busy), .o_done(o_done), .o_mem_en(o_mem_en),
        .o_node_addr(o_node_addr), .o_wegt_addr(o_wegt_addr), .o_bias_addr(o_bias_addr),
        .i_node_data(node_rd), .i_wegt_data(wegt_rd), .i_bias_data(bias_rd),
        .o_core_run(o_core_run), .o_core_valid(o_core_valid),
        .o_core_node(o_core_node), .o_core_wegt(o_core_wegt), .o_core_bias(o_core_bias),
        .i_core_result(acc), .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
        .o_res_data(o_res_data), .o_res_idx(o_res_idx), .o_state(dbg_state)
    );

    // ---------------- memories and core model ----------------
    logic signed [W-1:0] node_mem [NI];
    logic signed [W-1:0] wegt_mem [NI*NO];
    logic signed [W-1:0] bias_mem [NO];

    always_ff @(posedge clk) begin
        if (o_mem_en) begin
            node_rd <= node_mem[o_node_addr];
            wegt_rd <= wegt_mem[o_wegt_addr];
            bias_rd <= bias_mem[o_bias_addr];
        end
    end

    function automatic logic signed [RW-1:0] sx(input logic [W-1:0] v);
        return {{(RW-W){v[W-1]}}, v};
    endfunction

    always_ff @(posedge clk) begin
        if (o_core_run)        acc <= '0;
        else if (o_core_valid) acc <= acc + sx(o_core_node) * sx(o_core_wegt) + sx(o_core_bias);
    end

    // ---------------- scoreboard / checking ----------------
    logic [SBW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int res_cnt, done_cnt, first_valid_cyc, done_cyc, start_cyc;
    logic busy_at_done;

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (o_res_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (o_done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc     = cyc;
                    busy_at_done = o_busy;
                end
            end
            if (o_res_valid && i_res_ready) begin
                logic [SBW-1:0] e;
                res_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_result", RW'(exp_q.size()), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("res_data", o_res_data, e[RW-1:0]);
                    check("res_idx", RW'(o_res_idx), RW'(e[SBW-1:RW]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        res_cnt         = 0;
        done_cnt        = 0;
        first_valid_cyc = -1;
        done_cyc        = -1;
        busy_at_done    = 1'bx;
    endtask

    task automatic load_set(input int neg_row0);
        for (int k = 0; k < NI; k++) begin
            node_mem[k]        = W'(k + 1);
            wegt_mem[k]        = neg_row0 ? -8'sd10 : 8'sd1;
            wegt_mem[NI + k]   = (k % 2 == 0) ? -W'(k + 1) : W'(k + 1);
        end
        bias_mem[0] = neg_row0 ? 8'sd0 : 8'sd10;
        bias_mem[1] = -8'sd5;
    endtask

    task automatic push_expected();
        for (int n = 0; n < NO; n++) begin
            int sum = int'(bias_mem[n]);
            for (int k = 0; k < NI; k++) sum += int'(node_mem[k]) * int'(wegt_mem[n*NI + k]);
`ifdef FC_SEQ_RELU_EN
            if (sum < 0) sum = 0;
`endif
            exp_q.push_back({BAW'(n), RW'(sum)});
        end
    endtask

    task automatic start_layer();
        i_start   = 1'b1;
        start_cyc = cyc;
        next_cyc();
        i_start   = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while (done_cnt == 0 && i < budget) begin
            next_cyc();
            i++;
        end
        if (done_cnt == 0) check("done_timeout", RW'(done_cnt), 1);
        repeat (3) next_cyc();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, RW'({o_busy, o_done, o_mem_en, o_core_run, o_core_valid, o_res_valid}), 0);
        check({tag, "_addr"}, RW'({o_node_addr, o_wegt_addr, o_bias_addr}), 0);
        check({tag, "_ops"}, RW'({o_core_node, o_core_wegt, o_core_bias}), 0);
        check({tag, "_res"}, o_res_data, 0);
        check({tag, "_idx_state"}, RW'({o_res_idx, dbg_state}), 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int i;
        logic [RW-1:0] exp0;
        reset_n     = 1'b0;
        i_start     = 1'b0;
        i_res_ready = 1'b1;
        clear_stats();
        load_set(0);
        repeat (3) next_cyc();
        check_all_zero("reset");
        reset_n = 1'b1;
        next_cyc();

        // Basic layer with timing
        clear_stats();
        push_expected();
        start_layer();
        check("busy_rise", RW'(o_busy), 1);
        wait_done(100);
        check("t1_results", RW'(res_cnt), 2);
        check("t1_done_cnt", RW'(done_cnt), 1);
        check("t1_first_valid_lat", RW'(first_valid_cyc - start_cyc), 9);
        check("t1_done_lat", RW'(done_cyc - start_cyc), 20);
        check("t1_busy_at_done", RW'(busy_at_done), 0);
        check("t1_sb_empty", RW'(exp_q.size()), 0);

        // Backpressure on the first result
        clear_stats();
        push_expected();
        i_res_ready = 1'b0;
        start_layer();
        i = 0;
        while (!o_res_valid && i < 50) begin
            next_cyc();
            i++;
        end
        check("bp_valid_seen", RW'(o_res_valid), 1);
        for (int c = 0; c < 5; c++) begin
            check("bp_valid_held", RW'(o_res_valid), 1);
            check("bp_data_held", o_res_data, 20);
            check("bp_no_reads", RW'(o_mem_en), 0);
            next_cyc();
        end
        i_res_ready = 1'b1;
        wait_done(100);
        check("bp_results", RW'(res_cnt), 2);
        check("bp_done_cnt", RW'(done_cnt), 1);

        // Negative accumulation (clamped when the ReLU build is selected)
        clear_stats();
        load_set(1);
        push_expected();
        exp0 = exp_q[0][RW-1:0];
`ifdef FC_SEQ_RELU_EN
        check("neg_model", exp0, 0);
`else
        check("neg_model", exp0, -100);
`endif
        start_layer();
        wait_done(100);
        check("neg_results", RW'(res_cnt), 2);

        // Second start pulse during FEED is ignored
        clear_stats();
        load_set(0);
        push_expected();
        start_layer();
        i = 0;
        while (!o_mem_en && i < 20) begin
            next_cyc();
            i++;
        end
        check("rs_in_feed", RW'(o_mem_en), 1);
        i_start = 1'b1;
        next_cyc();
        i_start = 1'b0;
        wait_done(100);
        repeat (30) next_cyc();
        check("rs_results", RW'(res_cnt), 2);
        check("rs_done_cnt", RW'(done_cnt), 1);
        check("rs_idle", RW'(o_busy), 0);

        // Reset during FEED of neuron 1, then a clean layer
        clear_stats();
        push_expected();
        start_layer();
        i = 0;
        while (!(o_mem_en && o_bias_addr == 1'b1) && i < 40) begin
            next_cyc();
            i++;
        end
        check("rst_mid_feed_reached", RW'(o_bias_addr), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        exp_q.delete();
        repeat (2) next_cyc();
        check("rst_mid_res_cnt", RW'(res_cnt), 1);
        reset_n = 1'b1;
        repeat (5) next_cyc();
        check("rst_no_partial", RW'(o_res_valid), 0);
        clear_stats();
        push_expected();
        start_layer();
        wait_done(100);
        check("post_rst_results", RW'(res_cnt), 2);
        check("post_rst_done_cnt", RW'(done_cnt), 1);
        check("post_rst_sb_empty", RW'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
